// File: rtl/encap_packet.sv
// encap_packet: transmit-side Aurora encapsulator.
// Captures one DFX word (data + address) with the local router ID, then
// streams it to the Aurora TX user interface as NUMBER_PACKET 64-bit beats.
// Every beat carries a 9-bit header in its low bits:
//   [8:7] reserved (0), [6:2] beat number, [1:0] source router.
// The upper 55 bits carry consecutive 55-bit slices of the DFX word. The
// last beat carries the remaining 44 bits, zero-extended.
module encap_packet #(
  parameter int DATA_WIDTH        = 1024,
  parameter int ADDR_WIDTH        = 10,
  parameter int DATA_DFX_WIDTH    = DATA_WIDTH + ADDR_WIDTH,
  parameter int AURORA_DATA_WIDTH = 64,
  parameter int NUMBER_PACKET     = 19
) (
  input  logic                         clk,
  input  logic                         rst_n,
  // DFX side
  input  logic [DATA_DFX_WIDTH-1:0]    data_dfx_send,
  input  logic [1:0]                   src_router,
  input  logic                         valid_dfx_send,
  output logic                         dfx_ready,
  // Aurora TX side
  output logic [AURORA_DATA_WIDTH-1:0] tx_tdata,
  output logic                         tx_tvalid,
  output logic                         tx_tlast,
  input  logic                         tx_tready,
  // Completion
  output logic                         encap_done
);

  // Header layout inside each beat.
  localparam int HDR_W       = 9;
  localparam int CNT_W       = 5;
  localparam int PAYLOAD_W   = AURORA_DATA_WIDTH - HDR_W;
  // The frame is zero-extended so that the last slice can use the same
  // fixed-width part-select as every other beat.
  localparam int FRAME_PAD_W = NUMBER_PACKET * PAYLOAD_W;
  localparam int IDX_W       = $clog2(FRAME_PAD_W);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUMBER_PACKET - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e                         state_q,   state_d;
  logic [CNT_W-1:0]               pkt_cnt_q, pkt_cnt_d;
  logic [DATA_DFX_WIDTH-1:0]      frame_q,   frame_d;
  logic [1:0]                     src_q,     src_d;
  logic [AURORA_DATA_WIDTH-1:0]   tdata_q,   tdata_d;
  logic                           tlast_q,   tlast_d;

  logic                           xfer;

  // Builds beat k of a frame: 55-bit payload slice above a 9-bit header.
  function automatic logic [AURORA_DATA_WIDTH-1:0] build_beat(
    input logic [DATA_DFX_WIDTH-1:0] frame,
    input logic [1:0]                src,
    input logic [CNT_W-1:0]          k
  );
    logic [FRAME_PAD_W-1:0]       frame_pad;
    logic [IDX_W-1:0]             base;
    logic [AURORA_DATA_WIDTH-1:0] beat;
    frame_pad = FRAME_PAD_W'(frame);
    base      = IDX_W'(k) * IDX_W'(PAYLOAD_W);
    beat      = '0;
    beat[AURORA_DATA_WIDTH-1:HDR_W] = frame_pad[base +: PAYLOAD_W];
    beat[6:2] = k;
    beat[1:0] = src;
    return beat;
  endfunction

  assign xfer = tx_tvalid & tx_tready;

  // Next-state, beat counter, shadow frame and next output beat.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    state_d   = state_q;
    pkt_cnt_d = pkt_cnt_q;
    frame_d   = frame_q;
    src_d     = src_q;
    tdata_d   = tdata_q;
    tlast_d   = tlast_q;

    unique case (state_q)
      ST_IDLE: begin
        tdata_d = '0;
        tlast_d = 1'b0;
        if (valid_dfx_send) begin
          // Beat 0 is built straight from the inputs so it is on the bus
          // in the first cycle after acceptance.
          frame_d   = data_dfx_send;
          src_d     = src_router;
          pkt_cnt_d = '0;
          tdata_d   = build_beat(data_dfx_send, src_router, '0);
          tlast_d   = (LAST_BEAT == '0);
          state_d   = ST_SEND;
        end
      end

      ST_SEND: begin
        // Without a transfer the registered beat is simply held.
        if (xfer) begin
          if (pkt_cnt_q == LAST_BEAT) begin
            tdata_d = '0;
            tlast_d = 1'b0;
            state_d = ST_DONE;
          end else begin
            pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
            tdata_d   = build_beat(frame_q, src_q, pkt_cnt_q + CNT_W'(1));
            tlast_d   = ((pkt_cnt_q + CNT_W'(1)) == LAST_BEAT);
          end
        end
      end

      ST_DONE: begin
        tdata_d = '0;
        tlast_d = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        tdata_d = '0;
        tlast_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counter, shadow frame and registered beat outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pkt_cnt_q <= '0;
      // NOTE: the wide shadow frame is reset as well; it is an ordinary
      // register bank, not a RAM, and its reset value is defined as zero.
      frame_q   <= '0;
      src_q     <= '0;
      tdata_q   <= '0;
      tlast_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from the
      // values held before this edge.
      state_q   <= state_d;
      pkt_cnt_q <= pkt_cnt_d;
      frame_q   <= frame_d;
      src_q     <= src_d;
      tdata_q   <= tdata_d;
      tlast_q   <= tlast_d;
    end
  end

  // Status outputs are decodes of the state register.
  assign dfx_ready  = (state_q == ST_IDLE);
  assign tx_tvalid  = (state_q == ST_SEND);
  assign encap_done = (state_q == ST_DONE);
  assign tx_tdata   = tdata_q;
  assign tx_tlast   = tlast_q;

  // A stalled beat must stay on the bus unchanged until it is taken.
  a_hold_stable : assert property (
    @(posedge clk) disable iff (!rst_n)
      (tx_tvalid && !tx_tready) |=>
        (tx_tvalid && $stable(tx_tdata) && $stable(tx_tlast))
  );

endmodule

// File: tb/tb_encap_packet.sv
// Testbench for encap_packet: a transaction-level model turns every accepted
// DFX word into its expected list of beats, and one compare process checks
// all outputs against it on every falling edge. Directed sections add
// hand-computed literals for timing, headers and last-beat slicing.
module tb_encap_packet;

  localparam int DFX_W  = 1034;
  localparam int BEATS  = 19;
  localparam int SLICE  = 55;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [DFX_W-1:0] data_dfx_send = '0;
  logic [1:0]       src_router = '0;
  logic             valid_dfx_send = 1'b0;
  logic             dfx_ready;
  logic [63:0]      tx_tdata;
  logic             tx_tvalid;
  logic             tx_tlast;
  logic             tx_tready = 1'b1;
  logic             encap_done;

  encap_packet dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .data_dfx_send  (data_dfx_send),
    .src_router     (src_router),
    .valid_dfx_send (valid_dfx_send),
    .dfx_ready      (dfx_ready),
    .tx_tdata       (tx_tdata),
    .tx_tvalid      (tx_tvalid),
    .tx_tlast       (tx_tlast),
    .tx_tready      (tx_tready),
    .encap_done     (encap_done)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit bp_mode  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Model state
  logic [63:0] exp_q[$];
  bit          done_pending = 1'b0;
  bit          exp_valid, exp_done, exp_ready, exp_last;
  logic [63:0] exp_data;

  // Observation logs for the directed checks
  logic [63:0] log_beat[$];
  bit          log_last[$];
  int          log_bcyc[$];
  int          log_acc[$];
  int          log_done[$];
  int          stall_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Beat k of a word, bit by bit from the documented beat format.
  function automatic logic [63:0] spec_beat(input logic [DFX_W-1:0] w, input logic [1:0] src, input int k);
    logic [63:0] b;
    b = '0;
    for (int j = 0; j < SLICE; j++) begin
      int idx;
      idx = k * SLICE + j;
      if (idx < DFX_W) b[9 + j] = w[idx];
    end
    b[6:2] = 5'(k);
    b[1:0] = src;
    return b;
  endfunction

  function automatic logic [DFX_W-1:0] rand_word();
    logic [1055:0] t;
    for (int i = 0; i < 33; i++) t[i*32 +: 32] = $urandom;
    return t[DFX_W-1:0];
  endfunction

  // Compare process: checks every output every cycle, then advances the model.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check("rst_dfx_ready",  64'(dfx_ready),  64'd1);
        check("rst_tx_tvalid",  64'(tx_tvalid),  64'd0);
        check("rst_tx_tlast",   64'(tx_tlast),   64'd0);
        check("rst_tx_tdata",   tx_tdata,        64'd0);
        check("rst_encap_done", 64'(encap_done), 64'd0);
        exp_q.delete();
        done_pending = 1'b0;
      end else begin
        exp_valid = (exp_q.size() > 0);
        exp_done  = done_pending;
        exp_ready = !exp_valid && !exp_done;
        exp_data  = exp_valid ? exp_q[0] : 64'd0;
        exp_last  = exp_valid && (exp_q.size() == 1);
        check("dfx_ready",  64'(dfx_ready),  64'(exp_ready));
        check("tx_tvalid",  64'(tx_tvalid),  64'(exp_valid));
        check("tx_tdata",   tx_tdata,        exp_data);
        check("tx_tlast",   64'(tx_tlast),   64'(exp_last));
        check("encap_done", 64'(encap_done), 64'(exp_done));

        if (dfx_ready && valid_dfx_send) log_acc.push_back(cyc);
        if (tx_tvalid && tx_tready) begin
          log_beat.push_back(tx_tdata);
          log_last.push_back(tx_tlast);
          log_bcyc.push_back(cyc);
        end
        if (tx_tvalid && !tx_tready) stall_cnt++;
        if (encap_done) log_done.push_back(cyc);

        done_pending = 1'b0;
        if (exp_valid && tx_tready) begin
          void'(exp_q.pop_front());
          if (exp_q.size() == 0) done_pending = 1'b1;
        end
        if (exp_ready && valid_dfx_send)
          for (int k = 0; k < BEATS; k++)
            exp_q.push_back(spec_beat(data_dfx_send, src_router, k));
      end
    end
  end

  // Aurora-side ready: always 1, or random per cycle in backpressure mode.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      tx_tready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic clear_logs();
    log_beat.delete();
    log_last.delete();
    log_bcyc.delete();
    log_acc.delete();
    log_done.delete();
    stall_cnt = 0;
  endtask

  // Present a word and hold valid until it is taken; data is scrambled after.
  task automatic send_word(input logic [DFX_W-1:0] w, input logic [1:0] src);
    bit ok;
    ok = 1'b0;
    @(posedge clk);
    #1;
    data_dfx_send  = w;
    src_router     = src;
    valid_dfx_send = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (dfx_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check("accept_in_time", 64'(ok), 64'd1);
    @(posedge clk);
    #1;
    valid_dfx_send = 1'b0;
    data_dfx_send  = rand_word();
    src_router     = 2'($urandom);
  endtask

  task automatic wait_done(input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (encap_done) begin
        ok = 1'b1;
        break;
      end
    end
    check("done_in_time", 64'(ok), 64'd1);
    @(posedge clk);
  endtask

  initial begin
    logic [1039:0]    t;
    logic [DFX_W-1:0] w1, w2;
    logic [63:0]      b;
    int               ntl;
    bit               ok;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("hold_rst_ready", 64'(dfx_ready), 64'd1);
    check("hold_rst_tdata", tx_tdata,       64'd0);
    check("hold_rst_valid", 64'(tx_tvalid), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Back-to-back, incrementing byte pattern, src=2
    for (int i = 0; i < 130; i++) t[i*8 +: 8] = 8'(i);
    w1 = t[DFX_W-1:0];
    w2 = ~w1;
    clear_logs();
    send_word(w1, 2'd2);
    send_word(w2, 2'd2);
    wait_done(100);
    check("b2b_accepts", 64'(log_acc.size()),  64'd2);
    check("b2b_dones",   64'(log_done.size()), 64'd2);
    check("b2b_beats",   64'(log_beat.size()), 64'd38);
    if (log_acc.size() == 2 && log_done.size() == 2 && log_beat.size() == 38) begin
      check("b2b_first_beat_cyc", 64'(log_bcyc[0] - log_acc[0]), 64'd1);
      check("b2b_last_beat_cyc",  64'(log_bcyc[18] - log_acc[0]), 64'd19);
      check("b2b_done_cyc",       64'(log_done[0] - log_acc[0]), 64'd20);
      check("b2b_period",         64'(log_acc[1] - log_acc[0]), 64'd21);
      ntl = 0;
      for (int k = 0; k < BEATS; k++) begin
        b = log_beat[k];
        check("b2b_header", 64'(b[6:0]), 64'(k * 4 + 2));
        if (log_last[k]) ntl++;
      end
      check("b2b_tlast_count", 64'(ntl), 64'd1);
      check("b2b_tlast_beat18", 64'(log_last[18]), 64'd1);
      b = log_beat[0];
      check("b2b_beat0_payload", b, {t[54:0], 9'h002});
    end

    // Last-beat slicing
    clear_logs();
    send_word({44'hFFF_FFFF_FFFF, 990'h0}, 2'd1);
    wait_done(100);
    check("lb_beats", 64'(log_beat.size()), 64'd19);
    if (log_beat.size() == 19) begin
      check("lb_beat0",  log_beat[0],  64'h0000_0000_0000_0001);
      check("lb_beat17", log_beat[17], 64'h0000_0000_0000_0045);
      check("lb_beat18", log_beat[18], 64'h001F_FFFF_FFFF_FE49);
    end

    // Random backpressure
    bp_mode = 1'b1;
    for (int f = 0; f < 6; f++) begin
      clear_logs();
      repeat ($urandom_range(0, 3)) @(posedge clk);
      send_word(rand_word(), 2'($urandom));
      wait_done(400);
      check("bp_beats", 64'(log_beat.size()), 64'd19);
      if (log_acc.size() == 1 && log_done.size() == 1)
        check("bp_frame_len", 64'(log_done[0] - log_acc[0]), 64'(20 + stall_cnt));
      else
        check("bp_frame_seen", 64'(log_done.size()), 64'd1);
    end
    bp_mode = 1'b0;

    // Busy rejection
    w1 = rand_word();
    w2 = rand_word();
    clear_logs();
    send_word(w1, 2'd3);
    repeat (3) @(posedge clk);
    #1;
    data_dfx_send  = w2;
    src_router     = 2'd0;
    valid_dfx_send = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("busy_ready_low", 64'(dfx_ready), 64'd0);
    end
    @(posedge clk);
    #1;
    valid_dfx_send = 1'b0;
    wait_done(100);
    check("busy_accepts", 64'(log_acc.size()),  64'd1);
    check("busy_beats",   64'(log_beat.size()), 64'd19);
    if (log_beat.size() == 19)
      check("busy_beat5", log_beat[5], spec_beat(w1, 2'd3, 5));
    clear_logs();
    send_word(w2, 2'd0);
    wait_done(100);
    check("busy_second_accepts", 64'(log_acc.size()), 64'd1);
    if (log_beat.size() > 0)
      check("busy_second_beat0", log_beat[0], spec_beat(w2, 2'd0, 0));

    // Reset mid-frame after beat 7
    clear_logs();
    send_word(rand_word(), 2'd1);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (log_beat.size() >= 8) begin
        ok = 1'b1;
        break;
      end
    end
    check("mid_reach_beat7", 64'(ok), 64'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(tx_tvalid),  64'd0);
    check("mid_rst_tdata", tx_tdata,        64'd0);
    check("mid_rst_tlast", 64'(tx_tlast),   64'd0);
    check("mid_rst_ready", 64'(dfx_ready),  64'd1);
    check("mid_rst_done",  64'(encap_done), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("mid_no_done", 64'(log_done.size()), 64'd0);
    clear_logs();
    send_word(rand_word(), 2'd2);
    wait_done(100);
    check("post_rst_beats", 64'(log_beat.size()), 64'd19);
    if (log_beat.size() > 0) begin
      b = log_beat[0];
      check("post_rst_hdr", 64'(b[6:2]), 64'd0);
    end

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
